// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bus responder: register offsets, FSM encoding
// and the default base address.
package gpio_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0020;

  localparam logic [1:0] OFF_DATA_IN  = 2'd0;
  localparam logic [1:0] OFF_DATA_OUT = 2'd1;
  localparam logic [1:0] OFF_EDGE_STS = 2'd2;
  localparam logic [1:0] OFF_EDGE_MSK = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/gpio_in_cond.sv
// Input conditioning: 2-flop synchroniser, optional per-bit debounce
// (GPIO_DEBOUNCE_EN) and rising-edge detect on the conditioned value.
module gpio_in_cond #(
  parameter int GPIO_W = 10
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] din,
  output logic [GPIO_W-1:0] data_in,
  output logic [GPIO_W-1:0] edge_rise
);

  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [GPIO_W-1:0] prev;
  logic [GPIO_W-1:0] val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [GPIO_W-1:0] deb;
  logic [CW-1:0]     cnt [GPIO_W];

  // A bit flips only after DEB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < GPIO_W; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign val = deb;
`else
  assign val = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= val;
  end

  assign data_in   = val;
  assign edge_rise = val & ~prev;

endmodule

// File: rtl/gpio_bus_responder.sv
// Memory-mapped GPIO responder on the data-memory bus with a one-wait-state
// valid/ready handshake. Optional input debounce via GPIO_DEBOUNCE_EN.
//
// state   | meaning
// ST_IDLE | waiting for req_valid; captures the request when it arrives
// ST_RESP | req_ready high for one cycle, read data driven, store committed
module gpio_bus_responder
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          GPIO_W    = 10
`ifdef GPIO_DEBOUNCE_EN
  , parameter int        DEB_CYCLES = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic [31:0]       rsp_rdata,
  input  logic [GPIO_W-1:0] GPIO_Port_In,
  output logic [GPIO_W-1:0] GPIO_Port_Out,
  output logic              edge_pending
);

  state_t state, state_nxt;

  logic        we_q;
  logic        hit_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic [GPIO_W-1:0] data_in;
  logic [GPIO_W-1:0] edge_rise;
  logic [GPIO_W-1:0] data_out;
  logic [GPIO_W-1:0] edge_sts;
  logic [GPIO_W-1:0] edge_msk;
  logic [GPIO_W-1:0] sts_clr;
  logic              pend_q;
  logic              resp;
  logic              wr_en;
  logic [31:0]       rd_word;
  logic              unused_bits;

  gpio_in_cond #(
    .GPIO_W     (GPIO_W)
`ifdef GPIO_DEBOUNCE_EN
    , .DEB_CYCLES (DEB_CYCLES)
`endif
  ) u_in_cond (
    .clk       (clk),
    .rst       (rst),
    .din       (GPIO_Port_In),
    .data_in   (data_in),
    .edge_rise (edge_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      off_q   <= 2'd0;
      wdata_q <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      we_q    <= req_we;
      hit_q   <= (req_addr[31:4] == BASE_ADDR[31:4]);
      off_q   <= req_addr[3:2];
      wdata_q <= req_wdata;
    end
  end

  assign resp  = (state == ST_RESP);
  assign wr_en = resp && we_q && hit_q;

  assign sts_clr = (wr_en && off_q == OFF_EDGE_STS) ? wdata_q[GPIO_W-1:0] : '0;

  // New edges are ORed in after the clear, so a coincident edge survives W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      edge_sts <= '0;
      edge_msk <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (wr_en && off_q == OFF_DATA_OUT) data_out <= wdata_q[GPIO_W-1:0];
      if (wr_en && off_q == OFF_EDGE_MSK) edge_msk <= wdata_q[GPIO_W-1:0];
      edge_sts <= (edge_sts & ~sts_clr) | edge_rise;
      pend_q   <= |(edge_sts & edge_msk);
    end
  end

  always_comb begin
    rd_word = '0;
    case (off_q)
      OFF_DATA_IN:  rd_word = 32'(data_in);
      OFF_DATA_OUT: rd_word = 32'(data_out);
      OFF_EDGE_STS: rd_word = 32'(edge_sts);
      OFF_EDGE_MSK: rd_word = 32'(edge_msk);
      default:      rd_word = '0;
    endcase
  end

  // Reset during RESP drops the transaction, so the pulse is suppressed too.
  assign req_ready = resp && !rst;
  assign rsp_rdata = (req_ready && !we_q && hit_q) ? rd_word : '0;

  assign GPIO_Port_Out = data_out;
  assign edge_pending  = pend_q;

  assign unused_bits = ^{req_addr[1:0], wdata_q};

endmodule

// File: tb/tb_gpio_bus_responder.sv
// Scoreboard bench for gpio_bus_responder: expected read data is queued when a
// request is issued and compared whenever the DUT pulses req_ready.
module tb_gpio_bus_responder;

  localparam logic [31:0] BASE = 32'h1001_0020;
  localparam int          W    = 10;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int SETTLE   = 3 + DEB;
  localparam int EDGE_LAT = 3 + DEB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic [31:0]   rsp_rdata;
  logic [W-1:0]  GPIO_Port_In = '0;
  logic [W-1:0]  GPIO_Port_Out;
  logic          edge_pending;

  int n_vec = 0;
  int n_err = 0;
  int n_ready = 0;
  logic ready_prev = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  gpio_bus_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_rdata     (rsp_rdata),
    .GPIO_Port_In  (GPIO_Port_In),
    .GPIO_Port_Out (GPIO_Port_Out),
    .edge_pending  (edge_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (req_ready) begin
      sb_t e;
      n_ready++;
      chk("ready_adj", 32'(ready_prev), 32'd0);
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.tag, rsp_rdata, e.exp);
      end
    end
    ready_prev = req_ready;
  end

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string tag);
    int   n;
    logic got;
    sb_t  e;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    e.tag = tag;
    e.exp = we ? 32'd0 : exp;
    sb_q.push_back(e);
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (req_ready) got = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    if (!got) void'(sb_q.pop_back());
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int start;

    // reset
    cycles(2);
    @(negedge clk);
    chk("rst_out", 32'(GPIO_Port_Out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_pend", 32'(edge_pending), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    xfer(1'b0, BASE + 32'h8, '0, 32'd0, "rst_sts");

    // DATA_IN load; visible two cycles after the input changes
    GPIO_Port_In = 10'd2;
`ifdef GPIO_DEBOUNCE_EN
    cycles(SETTLE);
`endif
    xfer(1'b0, BASE + 32'h0, '0, 32'h2, "din_2");

    // DATA_OUT store/readback
    xfer(1'b1, BASE + 32'h4, 32'hFFFF_F3A5, 32'd0, "st_out");
    chk("out_3a5", 32'(GPIO_Port_Out), 32'h3A5);
    xfer(1'b0, BASE + 32'h4, '0, 32'h3A5, "rd_out");

    // edge capture and W1C
    xfer(1'b0, BASE + 32'h8, '0, 32'h2, "sts_b1");
    xfer(1'b1, BASE + 32'h8, 32'h3FF, 32'd0, "clr_all");
    xfer(1'b0, BASE + 32'h8, '0, 32'd0, "sts_clr");
    xfer(1'b1, BASE + 32'hC, 32'h1, 32'd0, "st_msk");
    GPIO_Port_In = 10'h003;
    cycles(SETTLE + 1);
    xfer(1'b0, BASE + 32'h8, '0, 32'h1, "sts_b0");
    xfer(1'b0, BASE + 32'hC, '0, 32'h1, "rd_msk");
    @(negedge clk);
    chk("pend_1", 32'(edge_pending), 32'd1);
    xfer(1'b1, BASE + 32'h8, 32'h1, 32'd0, "w1c");
    xfer(1'b0, BASE + 32'h8, '0, 32'd0, "sts_w1c");
    @(negedge clk);
    chk("pend_0", 32'(edge_pending), 32'd0);

    // edge arriving in the same cycle as the clear: set wins
    GPIO_Port_In = 10'h002;
    cycles(SETTLE + 1);
    xfer(1'b0, BASE + 32'h8, '0, 32'd0, "sts_pre");
    @(posedge clk); #1 GPIO_Port_In = 10'h003;
    repeat (EDGE_LAT - 3) @(posedge clk);
    xfer(1'b1, BASE + 32'h8, 32'h1, 32'd0, "w1c_race");
    xfer(1'b0, BASE + 32'h8, '0, 32'h1, "sts_race");

    // address miss: load returns 0, store has no effect
    xfer(1'b0, BASE + 32'h40, '0, 32'd0, "miss_ld");
    xfer(1'b1, BASE + 32'h44, 32'h155, 32'd0, "miss_st");
    chk("miss_out", 32'(GPIO_Port_Out), 32'h3A5);

    // back-to-back with valid held: exactly two non-adjacent pulses
    start = n_ready;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h4; req_wdata = '0;
    sb_q.push_back('{tag: "b2b_0", exp: 32'h3A5});
    sb_q.push_back('{tag: "b2b_1", exp: 32'h3A5});
    k = 0; n = 0;
    while (k < 2 && n < 12) begin
      @(negedge clk);
      n++;
      if (req_ready) k++;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    cycles(3);
    chk("b2b_cnt", 32'(n_ready - start), 32'd2);
    chk("b2b_span", 32'(n), 32'd4);

    // reset during RESP of a store drops it
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    chk("rst2_out", 32'(GPIO_Port_Out), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h4; req_wdata = 32'h155;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cycles(2);
    chk("rstmid_out", 32'(GPIO_Port_Out), 32'd0);
    xfer(1'b0, BASE + 32'h4, '0, 32'd0, "rstmid_rd");

`ifdef GPIO_DEBOUNCE_EN
    // debounce: short glitch ignored, stable change appears after 2+DEB
    GPIO_Port_In = 10'h000;
    cycles(SETTLE + 2);
    GPIO_Port_In = 10'h004;
    cycles(2);
    GPIO_Port_In = 10'h000;
    cycles(SETTLE + 2);
    xfer(1'b0, BASE + 32'h0, '0, 32'd0, "deb_glitch");
    @(posedge clk); #1 GPIO_Port_In = 10'h004;
    repeat (3) @(posedge clk);
    xfer(1'b0, BASE + 32'h0, '0, 32'd0, "deb_early");
    xfer(1'b0, BASE + 32'h0, '0, 32'h4, "deb_stable");
`endif

    cycles(2);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
